// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand FIFO feeding an external ALU, with a one-entry result register.
// Optional macro ALU_STICKY_OVF_EN enables the sticky overflow flag.
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [2:0]  ALU_operation,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [31:0] res,
    input  logic        zero,
    input  logic        overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic        out_zero,
    output logic        out_overflow,
    output logic [4:0]  fifo_count,
    input  logic        ovf_clr,
    output logic        sticky_ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    logic [2:0]    r_op_mem [DEPTH];
    logic [31:0]   r_a_mem  [DEPTH];
    logic [31:0]   r_b_mem  [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [4:0]    r_count;
    logic [4:0]    w_count_nxt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_empty;

    assign w_fifo_empty = (r_count == 5'd0);
    assign in_ready     = (r_count < 5'(DEPTH));
    assign fifo_count   = r_count;
    assign out_valid    = (r_state == ST_FULL);
    assign w_push       = in_valid && in_ready;
    // A capture pops the head whenever the result register is free or being drained.
    assign w_pop        = !w_fifo_empty && ((r_state == ST_EMPTY) || out_ready);

    // Head entry presented to the ALU, forced to zero while the FIFO is empty.
    always_comb begin
        ALU_operation = 3'd0;
        A             = 32'd0;
        B             = 32'd0;
        if (!w_fifo_empty) begin
            ALU_operation = r_op_mem[r_rptr];
            A             = r_a_mem[r_rptr];
            B             = r_b_mem[r_rptr];
        end else begin
            ALU_operation = 3'd0;
            A             = 32'd0;
            B             = 32'd0;
        end
    end

    // Operand storage write port; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wptr] <= in_op;
            r_a_mem[r_wptr]  <= in_a;
            r_b_mem[r_wptr]  <= in_b;
        end
    end

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 5'd1;
            2'b01:   w_count_nxt = r_count - 5'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Result register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result register next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_pop) w_state_nxt = ST_FULL;
                else       w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_pop)          w_state_nxt = ST_FULL;
                else if (out_ready) w_state_nxt = ST_EMPTY;
                else                w_state_nxt = ST_FULL;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Captured ALU result and flags; they hold after the register drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_res      <= 32'd0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
        end else if (w_pop) begin
            out_res      <= res;
            out_zero     <= zero;
            out_overflow <= overflow;
        end
    end

`ifdef ALU_STICKY_OVF_EN
    // Sticky overflow: a capturing overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (w_pop && overflow) begin
            sticky_ovf <= 1'b1;
        end else if (ovf_clr) begin
            sticky_ovf <= 1'b0;
        end
    end
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;
    assign sticky_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with a subtracting ALU model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  ALU_operation;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] res;
    logic        zero;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_zero;
    logic        out_overflow;
    logic [4:0]  fifo_count;
    logic        ovf_clr;
    logic        sticky_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q [5];
    logic        exp_sticky;

    alu_issue_stage #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .ALU_operation(ALU_operation), .A(A), .B(B),
        .res(res), .zero(zero), .overflow(overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_zero(out_zero), .out_overflow(out_overflow),
        .fifo_count(fifo_count), .ovf_clr(ovf_clr), .sticky_ovf(sticky_ovf)
    );

    always #5 clk = ~clk;

    // Environment ALU: subtract with signed-overflow detection.
    assign res      = A - B;
    assign zero     = (res == 32'd0);
    assign overflow = (A[31] != B[31]) && (res[31] != A[31]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
`ifdef ALU_STICKY_OVF_EN
        exp_sticky = 1'b1;
`else
        exp_sticky = 1'b0;
`endif
        rst_n = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_res", out_res, 32'd0);
        check("rst_sticky", {31'd0, sticky_ovf}, 32'd0);
        check("rst_A_empty", A, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single subtract 6-4, one-cycle latency.
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 32'd6, 32'd4);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        check("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
        check("lat_head_A", A, 32'd6);
        check("lat_head_op", {29'd0, ALU_operation}, 32'd7);
        tick();
        check("sub_valid", {31'd0, out_valid}, 32'd1);
        check("sub_res", out_res, 32'd2);
        check("sub_zero", {31'd0, out_zero}, 32'd0);
        check("sub_ovf", {31'd0, out_overflow}, 32'd0);
        check("sub_count", {27'd0, fifo_count}, 32'd0);
        tick();
        check("drain_empty", {31'd0, out_valid}, 32'd0);
        check("drain_res_hold", out_res, 32'd2);

        // Signed overflow and sticky flag.
        drive(1'b1, 3'd7, 32'h8000_0000, 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        check("ovf_res", out_res, 32'h7fff_ffff);
        check("ovf_flag", {31'd0, out_overflow}, 32'd1);
        check("ovf_sticky_set", {31'd0, sticky_ovf}, {31'd0, exp_sticky});
        tick();
        check("ovf_sticky_hold", {31'd0, sticky_ovf}, {31'd0, exp_sticky});
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_sticky_clr", {31'd0, sticky_ovf}, 32'd0);

        // Backpressure: five requests, four queued plus one captured.
        out_ready = 1'b0;
        exp_q[0] = 32'hffff_fe00; exp_q[1] = 32'h0000_0200; exp_q[2] = 32'hffff_fe60;
        exp_q[3] = 32'hffff_fe70; exp_q[4] = 32'hffff_fe80;
        drive(1'b1, 3'd7, 32'd64, 32'd576);  tick();
        drive(1'b1, 3'd7, 32'd576, 32'd64);  tick();
        drive(1'b1, 3'd7, 32'd0, 32'd416);   tick();
        drive(1'b1, 3'd7, 32'd16, 32'd416);  tick();
        drive(1'b1, 3'd7, 32'd32, 32'd416);  tick();
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_count", {27'd0, fifo_count}, 32'd4);
        check("bp_first_res", out_res, exp_q[0]);
        drive(1'b1, 3'd7, 32'd999, 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        check("bp_full_reject", {27'd0, fifo_count}, 32'd4);
        check("bp_hold_res", out_res, exp_q[0]);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            check($sformatf("bp_order_%0d", i), out_res, exp_q[i]);
            check($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
        end
        check("bp_count_drained", {27'd0, fifo_count}, 32'd0);
        tick();
        check("bp_final_empty", {31'd0, out_valid}, 32'd0);

        // Zero flag.
        drive(1'b1, 3'd7, 32'd16, 32'd16);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        check("zero_res", out_res, 32'd0);
        check("zero_flag", {31'd0, out_zero}, 32'd1);
        tick();

        // Reset with three queued entries and a captured result.
        out_ready = 1'b0;
        drive(1'b1, 3'd7, 32'd10, 32'd1); tick();
        drive(1'b1, 3'd7, 32'd11, 32'd1); tick();
        drive(1'b1, 3'd7, 32'd12, 32'd1); tick();
        drive(1'b1, 3'd7, 32'd13, 32'd1); tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        check("mrst_pre_count", {27'd0, fifo_count}, 32'd3);
        check("mrst_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_count", {27'd0, fifo_count}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mrst_out_res", out_res, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        check("mrst_no_stale", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 3'd7, 32'd9, 32'd3);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        check("mrst_fresh_res", out_res, 32'd6);
        check("mrst_fresh_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // Streaming: 20 back-to-back requests, res = 3i - i = 2i.
        for (int t = 0; t <= 20; t++) begin
            if (t < 20) drive(1'b1, 3'd7, 32'(3 * t), 32'(t));
            else        drive(1'b0, 3'd0, 32'd0, 32'd0);
            tick();
            if (t >= 1) begin
                check($sformatf("stream_valid_%0d", t), {31'd0, out_valid}, 32'd1);
                check($sformatf("stream_res_%0d", t), out_res, 32'(2 * (t - 1)));
            end
            check($sformatf("stream_ready_%0d", t), {31'd0, in_ready}, 32'd1);
        end
        tick();
        check("stream_end_empty", {31'd0, out_valid}, 32'd0);
        check("stream_end_count", {27'd0, fifo_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
